// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The CKSUM state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CKSUM,
    S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE
  } state_t;
`endif

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port.
// The master modport is the loader side, the slave modport is the host/memory side.
interface imem_loader_if #(
  parameter int AW = 6
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word assembler: the first byte of a word lands in bits [31:24].
// word is combinational so the caller can register it on the same edge that takes the last byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_done
);
  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane_q;
  logic [23:0]       shift_q;

  assign word      = {shift_q, data};
  assign word_done = shift_en && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (clear) begin
      lane_q  <= '0;
    end else if (shift_en) begin
      lane_q  <= lane_q + 1'b1;
      shift_q <= {shift_q[15:0], data};
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: count header, big-endian words to instruction memory, core held in reset until clean.
// Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
//
// state    | meaning
// IDLE     | waiting for first start
// LEN_HI   | taking word-count high byte
// LEN_LO   | taking word-count low byte, oversize decided here
// DATA     | taking 4*N data bytes, one write per word
// CKSUM    | taking the XOR checksum byte (checksum build only)
// DONE     | load finished, waiting for a new start
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_hold,
  output logic          done,
  output logic          err
);
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = S_CKSUM;
`else
  localparam state_t AFTER_DATA = S_DONE;
`endif

  state_t        state_q, state_d;
  logic [7:0]    len_hi_q;
  logic [15:0]   words_left_q;
  logic [AW-1:0] word_idx_q;
  logic [15:0]   n_count;
  logic [31:0]   word;
  logic          xfer, start_ok, word_done, last_word;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign n_count   = {len_hi_q, bus.in_data};
  assign last_word = word_done && (words_left_q == 16'd1);
  assign done      = (state_q == S_DONE);

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.in_ready = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CKSUM};
`else
  assign bus.in_ready = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA};
`endif

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .shift_en  (xfer && (state_q == S_DATA)),
    .data      (bus.in_data),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_LEN_HI;
      S_LEN_HI:       if (xfer) state_d = S_LEN_LO;
      S_LEN_LO:       if (xfer) state_d = (n_count == 16'd0) ? AFTER_DATA : S_DATA;
      S_DATA:         if (last_word) state_d = AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CKSUM:        if (xfer) state_d = S_DONE;
`endif
      default:        state_d = S_IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            csum_q <= 8'h00;
    else if (start_ok)                    csum_q <= 8'h00;
    else if (xfer && (state_q == S_DATA)) csum_q <= csum_q ^ bus.in_data;
  end
`endif

  // An oversize load still walks the whole stream; err_q alone suppresses its writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi_q     <= 8'h00;
      words_left_q <= 16'd0;
      word_idx_q   <= '0;
      err          <= 1'b0;
      core_hold    <= 1'b1;
      bus.we       <= 1'b0;
      bus.waddr    <= '0;
      bus.wdata    <= 32'h0;
    end else begin
      bus.we <= 1'b0;
      if (start_ok) begin
        err        <= 1'b0;
        core_hold  <= 1'b1;
        word_idx_q <= '0;
      end
      if (xfer && (state_q == S_LEN_HI)) len_hi_q <= bus.in_data;
      if (xfer && (state_q == S_LEN_LO)) begin
        words_left_q <= n_count;
        if (n_count > DEPTH_W) err <= 1'b1;
      end
      if (word_done) begin
        words_left_q <= words_left_q - 16'd1;
        word_idx_q   <= word_idx_q + 1'b1;
        if (!err) begin
          bus.we    <= 1'b1;
          bus.waddr <= word_idx_q;
          bus.wdata <= word;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (xfer && (state_q == S_CKSUM) && (bus.in_data != csum_q)) err <= 1'b1;
`endif
      if ((state_q == S_DONE) && !err && !start_ok) core_hold <= 1'b0;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole-stream loads plus hand-written reset/abort sequences.
// Define IMEM_LOADER_CHECKSUM_EN to exercise the checksum build.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic reset, start;
  logic core_hold, done, err;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] n;
    logic [3:0]  gap;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        bad_ck;
    logic        exp_err;
    logic        exp_hold;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int xfer_cnt = 0;
  int last_xfer_edge = -1;
  int done_cyc = -1;
  int hold_fall_cyc = -1;
  int long_we = 0;
  logic we_prev = 1'b0, done_prev = 1'b0, hold_prev = 1'b1;
  int wq_addr[$];
  logic [31:0] wq_data[$];
  int wq_cyc[$];

  always @(posedge clk) cyc++;

  // Sample just after the falling edge: bench drives are settled and DUT outputs are stable.
  always @(negedge clk) begin
    #1;
    if (bus.in_valid && bus.in_ready) begin
      xfer_cnt++;
      last_xfer_edge = cyc + 1;
    end
    if (bus.we) begin
      wq_addr.push_back(int'(bus.waddr));
      wq_data.push_back(bus.wdata);
      wq_cyc.push_back(cyc);
      if (we_prev) long_we++;
    end
    if (done && !done_prev) done_cyc = cyc;
    if (!core_hold && hold_prev) hold_fall_cyc = cyc;
    we_prev   = bus.we;
    done_prev = done;
    hold_prev = core_hold;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input vec_t v, input int i);
    logic [7:0] b;
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    b = 8'(i);
    return {b, 8'hA5, ~b, 8'(i * 3)};
  endfunction

  function automatic vec_t mk(input int n, input int gap, input logic [31:0] w0, input logic [31:0] w1,
                              input logic bad_ck, input logic exp_err, input logic exp_hold);
    vec_t v;
    v.n = 16'(n); v.gap = 4'(gap); v.w0 = w0; v.w1 = w1;
    v.bad_ck = bad_ck; v.exp_err = exp_err; v.exp_hold = exp_hold;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready timeout: got 0, required 1 within 20 cycles");
    end
    @(posedge clk);
    if (gap > 0) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    xfer_cnt      = 0;
    done_cyc      = -1;
    hold_fall_cyc = -1;
    long_we       = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input int idx, input vec_t v);
    logic [7:0]  ck;
    logic [31:0] w;
    int t, exp_w, exp_bytes;
    clear_log();
    pulse_start();
    check($sformatf("v%0d hold after start", idx), 32'(core_hold), 32'd1);
    check($sformatf("v%0d done after start", idx), 32'(done), 32'd0);
    check($sformatf("v%0d err after start", idx), 32'(err), 32'd0);
    send_byte(v.n[15:8], int'(v.gap));
    send_byte(v.n[7:0], int'(v.gap));
    ck = 8'h00;
    for (int i = 0; i < int'(v.n); i++) begin
      w = word_of(v, i);
      for (int b = 3; b >= 0; b--) begin
        send_byte(w[b*8 +: 8], int'(v.gap));
        ck ^= w[b*8 +: 8];
      end
    end
    exp_bytes = HDR_BYTES + BYTES_PER_WORD * int'(v.n);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(ck ^ {7'd0, v.bad_ck}, int'(v.gap));
    exp_bytes++;
`endif
    @(negedge clk);
    bus.in_valid = 1'b0;
    t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("v%0d done reached", idx), 32'(done), 32'd1);
    repeat (2) @(negedge clk);
    check($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
    check($sformatf("v%0d core_hold", idx), 32'(core_hold), 32'(v.exp_hold));
    check($sformatf("v%0d done sticky", idx), 32'(done), 32'd1);
    check($sformatf("v%0d in_ready in DONE", idx), 32'(bus.in_ready), 32'd0);
    check($sformatf("v%0d bytes accepted", idx), 32'(xfer_cnt), 32'(exp_bytes));
    check($sformatf("v%0d done timing", idx), 32'(done_cyc), 32'(last_xfer_edge));
    if (!v.exp_hold)
      check($sformatf("v%0d hold fall timing", idx), 32'(hold_fall_cyc), 32'(done_cyc + 1));
    check($sformatf("v%0d we width", idx), 32'(long_we), 32'd0);
    exp_w = (int'(v.n) > DEPTH) ? 0 : int'(v.n);
    check($sformatf("v%0d write count", idx), 32'(wq_addr.size()), 32'(exp_w));
    for (int i = 0; i < wq_addr.size() && i < exp_w; i++) begin
      check($sformatf("v%0d waddr[%0d]", idx, i), 32'(wq_addr[i]), 32'(i));
      check($sformatf("v%0d wdata[%0d]", idx, i), wq_data[i], word_of(v, i));
      if (v.gap == 4'd0 && i > 0)
        check($sformatf("v%0d we spacing[%0d]", idx, i), 32'(wq_cyc[i] - wq_cyc[i-1]), 32'd4);
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (exp_w > 0 && wq_cyc.size() > 0)
      check($sformatf("v%0d done with last we", idx), 32'(done_cyc), 32'(wq_cyc[wq_cyc.size()-1]));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t v4;
    logic [31:0] w;

    vecs.push_back(mk(2,  0, 32'h20010005, 32'hAC010000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(2,  3, 32'h20010005, 32'hAC010000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(0,  0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(64, 0, 32'h13000000, 32'h00000093, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(65, 0, 32'h11111111, 32'h22222222, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1,  1, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0));
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs.push_back(mk(1,  0, 32'h01020304, 32'h0,        1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1,  0, 32'h01020304, 32'h0,        1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(0,  0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1));
`endif

    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset we", 32'(bus.we), 32'd0);
    check("reset waddr", 32'(bus.waddr), 32'd0);
    check("reset wdata", bus.wdata, 32'd0);
    check("reset core_hold", 32'(core_hold), 32'd1);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle in_ready", 32'(bus.in_ready), 32'd0);
    check("idle core_hold", 32'(core_hold), 32'd1);

    foreach (vecs[i]) run_load(i, vecs[i]);

    // Abort: start mid-load must be ignored, then reset after two of four words.
    v4 = mk(4, 0, 32'hCAFEF00D, 32'h0BADBEEF, 1'b0, 1'b0, 1'b0);
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    for (int i = 0; i < 2; i++) begin
      w = word_of(v4, i);
      for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8], 0);
      if (i == 0) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort writes before reset", 32'(wq_addr.size()), 32'd2);
    if (wq_addr.size() >= 2) begin
      check("abort waddr[1]", 32'(wq_addr[1]), 32'd1);
      check("abort wdata[1]", wq_data[1], 32'h0BADBEEF);
    end
    check("abort in_ready mid-load", 32'(bus.in_ready), 32'd1);
    check("abort hold mid-load", 32'(core_hold), 32'd1);
    reset = 1'b1;
    #1;
    check("abort reset in_ready", 32'(bus.in_ready), 32'd0);
    check("abort reset we", 32'(bus.we), 32'd0);
    check("abort reset waddr", 32'(bus.waddr), 32'd0);
    check("abort reset wdata", bus.wdata, 32'd0);
    check("abort reset core_hold", 32'(core_hold), 32'd1);
    check("abort reset done", 32'(done), 32'd0);
    check("abort reset err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("abort no writes after reset", 32'(wq_addr.size()), 32'd2);
    run_load(100, v4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
